// File: rtl/ddr_pkg.sv
// ddr_pkg: shared widths, queue entry layout and FSM encoding
// for the DDR command queue (ddr_cmd_queue, ddr_sync_fifo).
package ddr_pkg;

  localparam int BA_W  = 2;
  localparam int ROW_W = 13;
  localparam int COL_W = 10;
  localparam int LEN_W = 4;

  localparam int ENTRY_W = 1 + BA_W + ROW_W + COL_W + LEN_W;

  localparam int ISSUE_TIMEOUT_DEF = 32;

  typedef struct packed {
    logic             wr;
    logic [BA_W-1:0]  ba;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [LEN_W-1:0] len;
  } cmd_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } cmd_state_t;

endpackage

// File: rtl/ddr_sync_fifo.sv
// ddr_sync_fifo: DEPTH x cmd_entry_t synchronous FIFO.
// Ports: clk, rst (sync high), push/wdata, pop/rdata, count/full/empty.
import ddr_pkg::*;

module ddr_sync_fifo #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  cmd_entry_t    wdata,
  output cmd_entry_t    rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  cmd_entry_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Power-of-2 depth: pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ddr_cmd_queue.sv
// ddr_cmd_queue: queues user read/write requests and issues them one at a
// time to a DDR controller (strobe until BUSY, retire on BUSY fall/timeout).
import ddr_pkg::*;

module ddr_cmd_queue #(
  parameter  int DEPTH         = 8,
  parameter  int ISSUE_TIMEOUT = ISSUE_TIMEOUT_DEF,
  localparam int CW            = $clog2(DEPTH) + 1,
  localparam int TW            = $clog2(ISSUE_TIMEOUT + 1)
) (
  input  logic             SYS_CLK_100M,
  input  logic             RESET,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic             REQ_WR,
  input  logic [BA_W-1:0]  REQ_BA,
  input  logic [ROW_W-1:0] REQ_ROW,
  input  logic [COL_W-1:0] REQ_COL,
  input  logic [LEN_W-1:0] REQ_LEN,
  output logic             WRITE,
  output logic             READ,
  output logic [BA_W-1:0]  BA_IN,
  output logic [ROW_W-1:0] ADDR_ROW_IN,
  output logic [COL_W-1:0] ADDR_COL_IN,
  output logic [LEN_W-1:0] WRITE_LENGTH,
  input  logic             BUSY,
  input  logic             PWR_ON,
  output logic [CW-1:0]    QUEUE_COUNT,
  output logic             QUEUE_EMPTY,
  output logic             QUEUE_FULL,
  output logic             ISSUE_DONE,
  output logic             TIMEOUT_FLAG
);

  cmd_state_t    state;
  cmd_state_t    state_nxt;
  cmd_entry_t    req_entry;
  cmd_entry_t    head;
  cmd_entry_t    cmd_q;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          retire;
  logic          tmo_retire;
  logic          start;
  logic          done_q;
  logic          tmo_q;

  assign req_entry = '{wr:  REQ_WR,  ba:  REQ_BA,
                       row: REQ_ROW, col: REQ_COL,
                       len: REQ_LEN};

  ddr_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (SYS_CLK_100M),
    .rst   (RESET),
    .push  (REQ_VALID),
    .pop   (retire),
    .wdata (req_entry),
    .rdata (head),
    .count (QUEUE_COUNT),
    .full  (QUEUE_FULL),
    .empty (QUEUE_EMPTY)
  );

  assign REQ_READY    = !QUEUE_FULL;
  assign ISSUE_DONE   = done_q;
  assign TIMEOUT_FLAG = tmo_q;
  assign tmo_hit      = (tmo_cnt == TW'(ISSUE_TIMEOUT - 1));
  assign start        = (state == ST_IDLE) &&
                        (state_nxt == ST_ISSUE);

  always_ff @(posedge SYS_CLK_100M) begin
    if (RESET) begin
      state   <= ST_IDLE;
      cmd_q   <= '0;
      tmo_cnt <= '0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= retire;
      if (tmo_retire) tmo_q <= 1'b1;
      if (start)      cmd_q <= head;
      // Counts strobe cycles spent without BUSY.
      if (state == ST_ISSUE) tmo_cnt <= tmo_cnt + TW'(1);
      else                   tmo_cnt <= '0;
    end
  end

  always_comb begin
    state_nxt  = state;
    retire     = 1'b0;
    tmo_retire = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!QUEUE_EMPTY && PWR_ON && !BUSY)
          state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (BUSY) begin
          state_nxt = ST_WAIT_DONE;
        end else if (tmo_hit) begin
          state_nxt  = ST_IDLE;
          retire     = 1'b1;
          tmo_retire = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!BUSY) begin
          state_nxt = ST_IDLE;
          retire    = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    WRITE        = 1'b0;
    READ         = 1'b0;
    BA_IN        = '0;
    ADDR_ROW_IN  = '0;
    ADDR_COL_IN  = '0;
    WRITE_LENGTH = '0;
    unique case (1'b1)
      (state == ST_ISSUE): begin
        WRITE        = cmd_q.wr;
        READ         = !cmd_q.wr;
        BA_IN        = cmd_q.ba;
        ADDR_ROW_IN  = cmd_q.row;
        ADDR_COL_IN  = cmd_q.col;
        WRITE_LENGTH = cmd_q.len;
      end
      (state == ST_WAIT_DONE): begin
        BA_IN        = cmd_q.ba;
        ADDR_ROW_IN  = cmd_q.row;
        ADDR_COL_IN  = cmd_q.col;
        WRITE_LENGTH = cmd_q.len;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ddr_cmd_queue.sv
// tb_ddr_cmd_queue: directed vector table plus hand sequences
// for timeout, full queue, push/pop overlap, power gating, reset.
module tb_ddr_cmd_queue;

  logic        SYS_CLK_100M = 1'b0;
  logic        RESET = 1'b0;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic        REQ_WR = 1'b0;
  logic [1:0]  REQ_BA = '0;
  logic [12:0] REQ_ROW = '0;
  logic [9:0]  REQ_COL = '0;
  logic [3:0]  REQ_LEN = '0;
  logic        WRITE;
  logic        READ;
  logic [1:0]  BA_IN;
  logic [12:0] ADDR_ROW_IN;
  logic [9:0]  ADDR_COL_IN;
  logic [3:0]  WRITE_LENGTH;
  logic        BUSY = 1'b0;
  logic        PWR_ON = 1'b1;
  logic [3:0]  QUEUE_COUNT;
  logic        QUEUE_EMPTY;
  logic        QUEUE_FULL;
  logic        ISSUE_DONE;
  logic        TIMEOUT_FLAG;

  always #5 SYS_CLK_100M = ~SYS_CLK_100M;

  ddr_cmd_queue #(.DEPTH(8), .ISSUE_TIMEOUT(32)) dut (
    .SYS_CLK_100M (SYS_CLK_100M),
    .RESET        (RESET),
    .REQ_VALID    (REQ_VALID),
    .REQ_READY    (REQ_READY),
    .REQ_WR       (REQ_WR),
    .REQ_BA       (REQ_BA),
    .REQ_ROW      (REQ_ROW),
    .REQ_COL      (REQ_COL),
    .REQ_LEN      (REQ_LEN),
    .WRITE        (WRITE),
    .READ         (READ),
    .BA_IN        (BA_IN),
    .ADDR_ROW_IN  (ADDR_ROW_IN),
    .ADDR_COL_IN  (ADDR_COL_IN),
    .WRITE_LENGTH (WRITE_LENGTH),
    .BUSY         (BUSY),
    .PWR_ON       (PWR_ON),
    .QUEUE_COUNT  (QUEUE_COUNT),
    .QUEUE_EMPTY  (QUEUE_EMPTY),
    .QUEUE_FULL   (QUEUE_FULL),
    .ISSUE_DONE   (ISSUE_DONE),
    .TIMEOUT_FLAG (TIMEOUT_FLAG)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge SYS_CLK_100M);
    #1;
  endtask

  task automatic do_reset();
    REQ_VALID = 1'b0;
    RESET = 1'b1;
    step();
    RESET = 1'b0;
  endtask

  task automatic push_req(input int wr, input int row);
    REQ_VALID = 1'b1;
    REQ_WR = wr[0];
    REQ_ROW = row[12:0];
    REQ_BA = 2'd1;
    REQ_COL = 10'd7;
    REQ_LEN = 4'd4;
    step();
    REQ_VALID = 1'b0;
  endtask

  // Rows of issued commands, captured on each strobe rise.
  logic prev_stb = 1'b0;
  int   log_q[$];
  always @(negedge SYS_CLK_100M) begin
    if ((WRITE || READ) && !prev_stb)
      log_q.push_back(int'(ADDR_ROW_IN));
    prev_stb <= WRITE || READ;
  end

  typedef struct {
    int rst, vld, wr, ba, row, col, len, busy, pwr;
    int e_cnt, e_rdy, e_full, e_emp, e_wr, e_rd, e_done;
    int e_ba, e_row, e_col, e_len;
  } vec_t;

  vec_t vt[9];

  initial begin
    int hi;
    int dn;
    int both;
    int stb;

    vt[0] = '{1,0,0,0,0,0,0,0,1, 0,1,0,1,0,0,0, 0,0,0,0};
    vt[1] = '{0,1,1,2,'h123,'h45,8,0,1, 1,1,0,0,0,0,0, 0,0,0,0};
    vt[2] = '{0,0,0,0,0,0,0,0,1, 1,1,0,0,1,0,0, 2,'h123,'h45,8};
    vt[3] = '{0,0,0,0,0,0,0,0,1, 1,1,0,0,1,0,0, 2,'h123,'h45,8};
    vt[4] = '{0,0,0,0,0,0,0,0,1, 1,1,0,0,1,0,0, 2,'h123,'h45,8};
    vt[5] = '{0,0,0,0,0,0,0,1,1, 1,1,0,0,0,0,0, 2,'h123,'h45,8};
    vt[6] = '{0,0,0,0,0,0,0,1,1, 1,1,0,0,0,0,0, 2,'h123,'h45,8};
    vt[7] = '{0,0,0,0,0,0,0,0,1, 0,1,0,1,0,0,1, 0,0,0,0};
    vt[8] = '{0,0,0,0,0,0,0,0,1, 0,1,0,1,0,0,0, 0,0,0,0};

    // Single write: reset, push, 3-cycle strobe, BUSY, retire.
    for (int i = 0; i < 9; i++) begin
      RESET = vt[i].rst[0];
      REQ_VALID = vt[i].vld[0];
      REQ_WR = vt[i].wr[0];
      REQ_BA = vt[i].ba[1:0];
      REQ_ROW = vt[i].row[12:0];
      REQ_COL = vt[i].col[9:0];
      REQ_LEN = vt[i].len[3:0];
      BUSY = vt[i].busy[0];
      PWR_ON = vt[i].pwr[0];
      step();
      chk($sformatf("v%0d count", i), int'(QUEUE_COUNT), vt[i].e_cnt);
      chk($sformatf("v%0d ready", i), int'(REQ_READY), vt[i].e_rdy);
      chk($sformatf("v%0d full", i), int'(QUEUE_FULL), vt[i].e_full);
      chk($sformatf("v%0d empty", i), int'(QUEUE_EMPTY), vt[i].e_emp);
      chk($sformatf("v%0d write", i), int'(WRITE), vt[i].e_wr);
      chk($sformatf("v%0d read", i), int'(READ), vt[i].e_rd);
      chk($sformatf("v%0d done", i), int'(ISSUE_DONE), vt[i].e_done);
      chk($sformatf("v%0d ba", i), int'(BA_IN), vt[i].e_ba);
      chk($sformatf("v%0d row", i), int'(ADDR_ROW_IN), vt[i].e_row);
      chk($sformatf("v%0d col", i), int'(ADDR_COL_IN), vt[i].e_col);
      chk($sformatf("v%0d len", i), int'(WRITE_LENGTH), vt[i].e_len);
    end
    RESET = 1'b0;
    REQ_VALID = 1'b0;
    chk("tmo flag clear", int'(TIMEOUT_FLAG), 0);

    // Read with BUSY never rising: 32-cycle strobe then timeout.
    do_reset();
    BUSY = 1'b0;
    push_req(0, 'h1AB);
    hi = 0;
    dn = 0;
    both = 0;
    for (int i = 0; i < 45; i++) begin
      step();
      if (i == 0) chk("latency read", int'(READ), 1);
      hi += int'(READ);
      dn += int'(ISSUE_DONE);
      if (READ && WRITE) both++;
    end
    chk("tmo read cycles", hi, 32);
    chk("tmo done pulses", dn, 1);
    chk("tmo both strobes", both, 0);
    chk("tmo flag", int'(TIMEOUT_FLAG), 1);
    chk("tmo count", int'(QUEUE_COUNT), 0);

    // Nine pushes into a queue held by BUSY.
    do_reset();
    chk("reset clears flag", int'(TIMEOUT_FLAG), 0);
    BUSY = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      push_req(1, 'h10 + k - 1);
      chk($sformatf("fill count %0d", k), int'(QUEUE_COUNT),
          (k > 8) ? 8 : k);
      if (k == 8) begin
        chk("fill ready", int'(REQ_READY), 0);
        chk("fill full", int'(QUEUE_FULL), 1);
      end
    end
    log_q.delete();
    BUSY = 1'b0;
    for (int i = 0; i < 400 && !QUEUE_EMPTY; i++) step();
    chk("drain empty", int'(QUEUE_EMPTY), 1);
    chk("drain issued", log_q.size(), 8);
    for (int k = 0; k < 8 && k < log_q.size(); k++)
      chk($sformatf("order %0d", k), log_q[k], 'h10 + k);

    // Push on the retire edge with count 3.
    do_reset();
    BUSY = 1'b1;
    for (int k = 0; k < 3; k++) push_req(1, 'h20 + k);
    BUSY = 1'b0;
    step();
    chk("c3 issue", int'(WRITE), 1);
    BUSY = 1'b1;
    step();
    chk("c3 wait count", int'(QUEUE_COUNT), 3);
    BUSY = 1'b0;
    push_req(1, 'h23);
    chk("c3 overlap count", int'(QUEUE_COUNT), 3);
    chk("c3 overlap done", int'(ISSUE_DONE), 1);

    // Push on the retire edge with the queue full.
    do_reset();
    BUSY = 1'b1;
    for (int k = 0; k < 8; k++) push_req(1, 'h30 + k);
    chk("c8 full", int'(QUEUE_FULL), 1);
    BUSY = 1'b0;
    step();
    BUSY = 1'b1;
    step();
    BUSY = 1'b0;
    REQ_VALID = 1'b1;
    step();
    chk("c8 retire count", int'(QUEUE_COUNT), 7);
    chk("c8 ready again", int'(REQ_READY), 1);
    step();
    REQ_VALID = 1'b0;
    chk("c8 refill count", int'(QUEUE_COUNT), 8);

    // Power gating.
    do_reset();
    PWR_ON = 1'b0;
    BUSY = 1'b0;
    push_req(1, 'h40);
    push_req(0, 'h41);
    stb = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      stb += int'(WRITE || READ);
    end
    chk("pwr off strobes", stb, 0);
    chk("pwr off count", int'(QUEUE_COUNT), 2);
    PWR_ON = 1'b1;
    step();
    chk("pwr on strobe", int'(WRITE), 1);
    chk("pwr on row", int'(ADDR_ROW_IN), 'h40);
    PWR_ON = 1'b0;
    step();
    chk("pwr drop keeps cmd", int'(WRITE), 1);
    PWR_ON = 1'b1;

    // Reset during WAIT_DONE with 4 queued.
    do_reset();
    BUSY = 1'b1;
    for (int k = 0; k < 4; k++) push_req(1, 'h50 + k);
    BUSY = 1'b0;
    step();
    BUSY = 1'b1;
    step();
    chk("rst pre count", int'(QUEUE_COUNT), 4);
    RESET = 1'b1;
    step();
    chk("rst count", int'(QUEUE_COUNT), 0);
    chk("rst write", int'(WRITE), 0);
    chk("rst read", int'(READ), 0);
    chk("rst done", int'(ISSUE_DONE), 0);
    chk("rst ready", int'(REQ_READY), 1);
    chk("rst row", int'(ADDR_ROW_IN), 0);
    RESET = 1'b0;
    BUSY = 1'b0;
    step();
    chk("rst post done", int'(ISSUE_DONE), 0);
    chk("rst post count", int'(QUEUE_COUNT), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/ddr_cmd_queue.md
DDR_CMD_QUEUE -- requirements
Module: ddr_cmd_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, queue entries (power of 2, 2..32).
REQ-002 SHALL have parameter ISSUE_TIMEOUT, default 32, SYS_CLK_100M cycles to wait for BUSY rise before retiring.
REQ-003 SHALL have port SYS_CLK_100M  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port RESET  in  1  synchronous active-high reset.
REQ-005 SHALL have ports REQ_VALID in 1 / REQ_READY out 1: user request handshake.
REQ-006 SHALL have ports REQ_WR in 1 (1 write, 0 read), REQ_BA in 2, REQ_ROW in 13, REQ_COL in 10, REQ_LEN in 4: request fields.
REQ-007 SHALL have ports WRITE out 1, READ out 1, BA_IN out 2, ADDR_ROW_IN out 13, ADDR_COL_IN out 10, WRITE_LENGTH out 4: command to downstream DDR controller.
REQ-008 SHALL have ports BUSY in 1 and PWR_ON in 1: controller status.
REQ-009 SHALL have ports QUEUE_COUNT out $clog2(DEPTH)+1, QUEUE_EMPTY out 1, QUEUE_FULL out 1, ISSUE_DONE out 1 (one-cycle retire pulse), TIMEOUT_FLAG out 1 (sticky).

Function
REQ-010 SHALL accept a request on any edge where REQ_VALID && REQ_READY; REQ_READY = (QUEUE_COUNT < DEPTH), no same-cycle pass-through.
REQ-011 SHALL store 30-bit entries {wr, ba, row, col, len} in FIFO order; pointers wrap modulo DEPTH.
REQ-012 SHALL run FSM states IDLE, ISSUE, WAIT_DONE.
REQ-013 IDLE -> ISSUE when queue non-empty && PWR_ON && !BUSY; head entry latched onto command outputs on that edge.
REQ-014 In ISSUE, SHALL hold WRITE (wr=1) or READ (wr=0) high, never both, with BA_IN/ADDR_ROW_IN/ADDR_COL_IN/WRITE_LENGTH stable.
REQ-015 ISSUE -> WAIT_DONE on first cycle BUSY=1; strobe deasserts on that edge.
REQ-016 ISSUE -> IDLE after ISSUE_TIMEOUT cycles without BUSY; entry retired, ISSUE_DONE pulsed, TIMEOUT_FLAG set.
REQ-017 WAIT_DONE -> IDLE on first cycle BUSY=0; entry popped, ISSUE_DONE pulsed.
REQ-018 Pop SHALL occur only at retire; head entry remains in queue and counted while ISSUE/WAIT_DONE.
REQ-019 Latency: request accepted at edge N into empty queue, controller idle -> strobe high from edge N+1.
REQ-020 Simultaneous push and pop SHALL leave QUEUE_COUNT unchanged; push when full is ignored.
REQ-021 PWR_ON low SHALL hold FSM in IDLE; PWR_ON falling during ISSUE/WAIT_DONE SHALL NOT abort the command.
REQ-022 Command field outputs SHALL be 0 in IDLE.
REQ-023 QUEUE_EMPTY = (count==0), QUEUE_FULL = (count==DEPTH), both registered-consistent with QUEUE_COUNT.

Reset
REQ-024 RESET SHALL, on next rising edge, clear pointers/count, flush queue, force IDLE, drive WRITE/READ/ISSUE_DONE/TIMEOUT_FLAG and all command fields to 0, REQ_READY to 1.
REQ-025 RESET mid-ISSUE/WAIT_DONE SHALL drop the in-flight command without ISSUE_DONE.

Structure
REQ-026 Package ddr_pkg SHALL hold entry field widths, entry struct, FSM state encoding, ISSUE_TIMEOUT default.
REQ-027 Storage SHALL be sub-module ddr_sync_fifo (DEPTH x 30, push/pop/count/full/empty); FSM and timeout counter in ddr_cmd_queue.

Verification
REQ-028 Single write {wr=1,ba=2,row=0x0123,col=0x045,len=8}, BUSY rises 3 cycles later, falls 20 later -> WRITE high 3 cycles, fields match, one ISSUE_DONE, count 1->0.
REQ-029 Read with BUSY held 0 -> READ high exactly 32 cycles, then ISSUE_DONE, TIMEOUT_FLAG=1.
REQ-030 Push 9 requests back-to-back, BUSY=1 -> REQ_READY low after 8th, QUEUE_FULL=1, 9th not stored; release BUSY -> issued in order.
REQ-031 Push on same edge as retire with count=8 -> count stays 8 only if push allowed next cycle; with count=3, count stays 3.
REQ-032 PWR_ON=0 with 2 queued -> no strobes; PWR_ON=1 -> first strobe next edge.
REQ-033 RESET during WAIT_DONE with 4 queued -> next edge count 0, WRITE/READ 0, no ISSUE_DONE.
